// File: rtl/i2c_reg_sequencer.sv
// Wishbone sequencer for an i2c_master_top core: runs the prescale/enable init, then turns
// single-byte register read/write commands into complete I2C transactions.
//
// state     | meaning
// S_INIT    | three init writes (PRERlo, PRERhi, CTR enable)
// S_IDLE    | cmd_ready high, waiting for a command
// S_TXR     | write TXR for the current byte phase
// S_CR      | write CR for the current byte phase
// S_WAIT    | settle / spacing delay before the next SR poll
// S_POLL    | read SR, check TIP and flags
// S_RXR     | read the received byte
// S_AB_CR   | write CR=STO after NACK or timeout
// S_AB_WAIT | delay before the next abort SR poll
// S_AB_POLL | read SR until the STOP has finished
// S_DONE    | rsp_valid pulse
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'd95,
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_TXR, S_CR, S_WAIT, S_POLL, S_RXR,
    S_AB_CR, S_AB_WAIT, S_AB_POLL, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  init_idx, init_idx_n;
  logic [1:0]  ph, ph_n;
  logic        rnw_q, rnw_n;
  logic [7:0]  reg_q, reg_n;
  logic [7:0]  wdata_q, wdata_n;
  logic [2:0]  timer, timer_n;
  logic [15:0] poll_cnt, poll_cnt_n;
  logic [1:0]  status_n;
  logic [7:0]  rdata_n;
  logic [2:0]  adr_n;
  logic [7:0]  dat_n;
  logic        we_n, cyc_n;

  logic        bus_state, bus_we, acked, rd_byte;
  logic [2:0]  bus_adr;
  logic [7:0]  bus_dat, txr_dat, cr_dat;
  logic [1:0]  last_ph;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign wb_stb_o  = wb_cyc_o;
  assign rd_byte   = rnw_q && (ph == 2'd3);
  assign last_ph   = rnw_q ? 2'd3 : 2'd2;

  always_comb begin
    txr_dat = {SLAVE_ADDR, 1'b0};
    cr_dat  = 8'h90;
    case (ph)
      2'd1: begin txr_dat = reg_q; cr_dat = 8'h10; end
      2'd2: begin
        txr_dat = rnw_q ? {SLAVE_ADDR, 1'b1} : wdata_q;
        cr_dat  = rnw_q ? 8'h90 : 8'h50;
      end
      2'd3: cr_dat = 8'h68;
      default: ;
    endcase
  end

  // what the current state puts on the bus, if it is a bus state
  always_comb begin
    bus_state = 1'b1;
    bus_adr   = 3'd4;
    bus_dat   = 8'h00;
    bus_we    = 1'b0;
    case (state)
      S_INIT: begin
        bus_adr = {1'b0, init_idx};
        bus_we  = 1'b1;
        case (init_idx)
          2'd0:    bus_dat = PRESCALE[7:0];
          2'd1:    bus_dat = PRESCALE[15:8];
          default: bus_dat = 8'h80;
        endcase
      end
      S_TXR:     begin bus_adr = 3'd3; bus_dat = txr_dat; bus_we = 1'b1; end
      S_CR:      begin bus_dat = cr_dat; bus_we = 1'b1; end
      S_AB_CR:   begin bus_dat = 8'h40; bus_we = 1'b1; end
      S_RXR:     bus_adr = 3'd3;
      S_POLL, S_AB_POLL: ;
      default:   bus_state = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    init_idx_n = init_idx;
    ph_n       = ph;
    rnw_n      = rnw_q;
    reg_n      = reg_q;
    wdata_n    = wdata_q;
    timer_n    = timer;
    poll_cnt_n = poll_cnt;
    status_n   = rsp_status;
    rdata_n    = rsp_rdata;
    adr_n      = wb_adr_o;
    dat_n      = wb_dat_o;
    we_n       = wb_we_o;
    cyc_n      = wb_cyc_o;
    acked      = 1'b0;

    // cyc low in a bus state means the previous access has fully ended, so launch
    if (bus_state) begin
      if (!wb_cyc_o) begin
        cyc_n = 1'b1;
        adr_n = bus_adr;
        dat_n = bus_dat;
        we_n  = bus_we;
      end else if (wb_ack_i) begin
        cyc_n = 1'b0;
        adr_n = 3'd0;
        dat_n = 8'h00;
        we_n  = 1'b0;
        acked = 1'b1;
      end
    end

    case (state)
      S_INIT: if (acked) begin
        if (init_idx == 2'd2) begin
          init_idx_n = 2'd0;
          state_n    = S_IDLE;
        end else begin
          init_idx_n = init_idx + 2'd1;
        end
      end
      S_IDLE: if (cmd_valid) begin
        rnw_n    = cmd_rnw;
        reg_n    = cmd_reg;
        wdata_n  = cmd_wdata;
        status_n = 2'b00;
        rdata_n  = 8'h00;
        ph_n     = 2'd0;
        state_n  = S_TXR;
      end
      S_TXR: if (acked) state_n = S_CR;
      S_CR: if (acked) begin
        timer_n    = 3'd3;
        poll_cnt_n = POLL_LIMIT;
        state_n    = S_WAIT;
      end
      S_WAIT: begin
        if (timer == 3'd0) state_n = S_POLL;
        else               timer_n = timer - 3'd1;
      end
      S_POLL: if (acked) begin
        if (wb_dat_i[1]) begin
          if (poll_cnt <= 16'd1) begin
            status_n = 2'b10;
            state_n  = S_AB_CR;
          end else begin
            poll_cnt_n = poll_cnt - 16'd1;
            timer_n    = 3'd7;
            state_n    = S_WAIT;
          end
        end else if (wb_dat_i[5]) begin
          status_n = 2'b11;
          state_n  = S_DONE;
        end else if (wb_dat_i[7] && !rd_byte) begin
          status_n = 2'b01;
          state_n  = S_AB_CR;
        end else if (ph == last_ph) begin
          state_n = rnw_q ? S_RXR : S_DONE;
        end else begin
          ph_n    = ph + 2'd1;
          state_n = (rnw_q && ph == 2'd2) ? S_CR : S_TXR;
        end
      end
      S_RXR: if (acked) begin
        rdata_n = wb_dat_i;
        state_n = S_DONE;
      end
      S_AB_CR: if (acked) begin
        timer_n = 3'd3;
        state_n = S_AB_WAIT;
      end
      S_AB_WAIT: begin
        if (timer == 3'd0) state_n = S_AB_POLL;
        else               timer_n = timer - 3'd1;
      end
      S_AB_POLL: if (acked) begin
        if (wb_dat_i[1]) begin
          timer_n = 3'd7;
          state_n = S_AB_WAIT;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_idx   <= 2'd0;
      ph         <= 2'd0;
      rnw_q      <= 1'b0;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
      timer      <= 3'd0;
      poll_cnt   <= 16'd0;
      rsp_status <= 2'b00;
      rsp_rdata  <= 8'h00;
      wb_adr_o   <= 3'd0;
      wb_dat_o   <= 8'h00;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
    end else begin
      state      <= state_n;
      init_idx   <= init_idx_n;
      ph         <= ph_n;
      rnw_q      <= rnw_n;
      reg_q      <= reg_n;
      wdata_q    <= wdata_n;
      timer      <= timer_n;
      poll_cnt   <= poll_cnt_n;
      rsp_status <= status_n;
      rsp_rdata  <= rdata_n;
      wb_adr_o   <= adr_n;
      wb_dat_o   <= dat_n;
      wb_we_o    <= we_n;
      wb_cyc_o   <= cyc_n;
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: a transaction-level stand-in for the I2C core plus slave device,
// and a command-level model of the expected register writes and responses.
module tb_i2c_reg_sequencer;
  localparam logic [6:0] SA = 7'h3C;
  localparam int         PL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rnw, rsp_valid;
  logic [7:0] cmd_reg, cmd_wdata, rsp_rdata;
  logic [1:0] rsp_status;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.PRESCALE(16'd95), .SLAVE_ADDR(SA), .POLL_LIMIT(16'(PL))) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // core + slave device stand-in
  logic [7:0]  dev_mem[256];
  logic [7:0]  ref_mem[256];
  logic [7:0]  txr_q, rxr_q, ptr;
  logic        rxack, al, addressed, rd_mode, dev_present;
  int          tip_left, byte_idx, cr_count, al_at, hang_at, hang_polls;
  int          last_ack, last_sr_start, acc_cnt;
  bit          hang_active, last_ack_cr;
  logic [10:0] wq[$];

  function automatic void core_cr(input logic [7:0] v);
    hang_active = 1'b0;
    al          = 1'b0;
    if (v != 8'h40 && cr_count == al_at) begin
      al        = 1'b1;
      addressed = 1'b0;
      tip_left  = $urandom_range(0, 2);
    end else if (v != 8'h40 && cr_count == hang_at) begin
      hang_active = 1'b1;
      hang_polls  = 0;
      tip_left    = 1000000;
    end else begin
      tip_left = $urandom_range(0, 3);
      if (v[7]) byte_idx = 0;
      if (v[4]) begin
        if (byte_idx == 0) begin
          addressed = dev_present && (txr_q[7:1] == SA);
          rd_mode   = txr_q[0];
          rxack     = !addressed;
        end else if (addressed && !rd_mode) begin
          if (byte_idx == 1) ptr = txr_q;
          else begin dev_mem[ptr] = txr_q; ptr = ptr + 8'd1; end
          rxack = 1'b0;
        end else rxack = 1'b1;
        byte_idx++;
      end
      if (v[5]) begin
        rxr_q = addressed ? dev_mem[ptr] : 8'hFF;
        if (addressed) ptr = ptr + 8'd1;
        rxack = v[3];
        byte_idx++;
      end
      if (v[6]) addressed = 1'b0;
    end
    cr_count++;
  endfunction

  function automatic logic [7:0] core_sr();
    logic tip;
    tip = (tip_left > 0);
    if (tip) begin
      tip_left--;
      if (hang_active) hang_polls++;
    end
    return {rxack, 1'b0, al, 3'b000, tip, 1'b0};
  endfunction

  initial begin
    int          wait_cnt;
    logic [10:0] req;
    logic        req_we;
    wb_ack_i = 1'b0; wb_dat_i = 8'h00; wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb_ack_i = 1'b0; wait_cnt = 0;
      end else if (wb_ack_i) begin
        wb_ack_i = 1'b0; wb_dat_i = 8'h00;
        check_val("wb_release", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 0);
      end else if (wb_cyc_o) begin
        if (wait_cnt == 0) begin
          req = {wb_adr_o, wb_dat_o}; req_we = wb_we_o;
          wait_cnt = $urandom_range(1, 3);
          check_val("wb_stb", 32'(wb_stb_o), 1);
          if (!wb_we_o && wb_adr_o == 3'd4) begin
            if (last_ack_cr) check_val("poll_after_cr", 32'(cyc_cnt - last_ack >= 5), 1);
            else             check_val("poll_spacing", 32'(cyc_cnt - last_sr_start >= 8), 1);
            last_sr_start = cyc_cnt;
          end
        end else begin
          check_val("wb_hold", 32'({wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 32'({1'b1, req_we, req}));
        end
        wait_cnt--;
        if (wait_cnt == 0) begin
          if (req_we) begin
            wq.push_back(req);
            if (req[10:8] == 3'd3)      txr_q = req[7:0];
            else if (req[10:8] == 3'd4) core_cr(req[7:0]);
          end else begin
            wb_dat_i = (req[10:8] == 3'd4) ? core_sr() : rxr_q;
          end
          last_ack    = cyc_cnt;
          last_ack_cr = req_we && (req[10:8] == 3'd4);
          acc_cnt++;
          wb_ack_i = 1'b1;
        end
      end
    end
  end

  task automatic check_init();
    logic [10:0] ie[3];
    ie[0] = {3'd0, 8'h5F}; ie[1] = {3'd1, 8'h00}; ie[2] = {3'd2, 8'h80};
    check_val("init_count", wq.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wq.size()) check_val("init_write", 32'(wq[i]), 32'(ie[i]));
  endtask

  task automatic run_cmd(input bit rnw, input logic [7:0] r, input logic [7:0] wd,
                         input bit present, input int al_p, input int hang_p, input bit hold);
    logic [10:0] ew[$];
    logic [1:0]  es;
    logic [7:0]  ed;
    int          nph, n;
    nph = rnw ? 4 : 3; es = 2'b00; ed = 8'h00;
    for (int p = 0; p < nph; p++) begin
      case (p)
        0: begin ew.push_back({3'd3, SA, 1'b0}); ew.push_back({3'd4, 8'h90}); end
        1: begin ew.push_back({3'd3, r}); ew.push_back({3'd4, 8'h10}); end
        2: if (rnw) begin ew.push_back({3'd3, SA, 1'b1}); ew.push_back({3'd4, 8'h90}); end
           else     begin ew.push_back({3'd3, wd}); ew.push_back({3'd4, 8'h50}); end
        default: ew.push_back({3'd4, 8'h68});
      endcase
      if (p == al_p) begin es = 2'b11; break; end
      if (p == hang_p) begin es = 2'b10; ew.push_back({3'd4, 8'h40}); break; end
      if (p == 0 && !present) begin es = 2'b01; ew.push_back({3'd4, 8'h40}); break; end
    end
    if (es == 2'b00) begin
      if (rnw) ed = ref_mem[r];
      else     ref_mem[r] = wd;
    end

    dev_present = present; al_at = al_p; hang_at = hang_p; cr_count = 0;
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_reg = r; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    check_val("accept_ready", 32'(cmd_ready), 1);
    wq.delete();
    @(negedge clk);
    check_val("ready_drop", 32'(cmd_ready), 0);
    if (!hold) cmd_valid = 1'b0;
    {cmd_rnw, cmd_reg, cmd_wdata} = 17'($urandom);
    n = 0;
    while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
    check_val("rsp_seen", 32'(rsp_valid), 1);
    check_val("rsp_status", 32'(rsp_status), 32'(es));
    check_val("rsp_rdata", 32'(rsp_rdata), 32'(ed));
    check_val("rsp_latency", cyc_cnt - last_ack, 1);
    check_val("wb_seq_len", wq.size(), ew.size());
    for (int i = 0; i < ew.size(); i++)
      if (i < wq.size()) check_val("wb_seq", 32'(wq[i]), 32'(ew[i]));
    if (es == 2'b10) check_val("poll_limit", hang_polls, PL);
    if (!hold) begin
      @(negedge clk);
      check_val("rsp_pulse", 32'(rsp_valid), 0);
      check_val("ready_back", 32'(cmd_ready), 1);
      check_val("rdata_hold", 32'(rsp_rdata), 32'(ed));
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, snap, f, al_p, hang_p;
    bit         seen, rnw, present;
    logic [7:0] r, wd;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_reg = 8'h00; cmd_wdata = 8'h00;
    dev_present = 1'b1; al_at = -1; hang_at = -1;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[5] = 8'h34; ref_mem[5] = 8'h34;

    repeat (3) @(negedge clk);
    check_val("reset_outputs", 32'({cmd_ready, rsp_valid, rsp_status, rsp_rdata, wb_cyc_o,
                                    wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 0);
    wq.delete();
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    check_val("init_ready", 32'(cmd_ready), 1);
    check_init();
    snap = acc_cnt;
    repeat (60) @(negedge clk);
    check_val("idle_quiet", acc_cnt, snap);
    check_val("idle_ready", 32'(cmd_ready), 1);

    run_cmd(1'b0, 8'h01, 8'hA5, 1'b1, -1, -1, 1'b0);
    run_cmd(1'b1, 8'h01, 8'h00, 1'b1, -1, -1, 1'b0);
    run_cmd(1'b1, 8'h05, 8'h00, 1'b1, -1, -1, 1'b0);
    run_cmd(1'b0, 8'h02, 8'h55, 1'b0, -1, -1, 1'b0);
    run_cmd(1'b1, 8'h01, 8'h00, 1'b1, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++)
      run_cmd(1'b0, 8'(i), 8'(8'h10 + i), 1'b1, -1, -1, i != 3);
    for (int i = 0; i < 4; i++)
      run_cmd(1'b1, 8'(i), 8'h00, 1'b1, -1, -1, 1'b0);
    run_cmd(1'b1, 8'h02, 8'h00, 1'b1, 2, -1, 1'b0);
    run_cmd(1'b0, 8'h03, 8'h77, 1'b1, -1, 2, 1'b0);
    run_cmd(1'b1, 8'h03, 8'h00, 1'b1, -1, 3, 1'b0);
    run_cmd(1'b1, 8'h03, 8'h00, 1'b1, -1, -1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      rnw = 1'($urandom_range(0, 1));
      r = 8'($urandom_range(0, 7));
      wd = 8'($urandom);
      f = $urandom_range(0, 9);
      present = 1'b1; al_p = -1; hang_p = -1;
      case (f)
        0: present = 1'b0;
        1: al_p = $urandom_range(0, rnw ? 3 : 2);
        2: hang_p = $urandom_range(0, rnw ? 3 : 2);
        default: ;
      endcase
      run_cmd(rnw, r, wd, present, al_p, hang_p, 1'b0);
    end

    // reset in the middle of the register-index byte
    dev_present = 1'b1; al_at = -1; hang_at = -1; cr_count = 0;
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_reg = 8'h04; cmd_wdata = 8'hEE;
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    wq.delete();
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (wq.size() < 3 && n < 500) begin @(negedge clk); n++; end
    check_val("mid_reached", 32'(wq.size() >= 3), 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_cyc", 32'(wb_cyc_o), 0);
    @(negedge clk);
    wq.delete();
    rst = 1'b0;
    seen = 1'b0; n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      n++;
    end
    check_val("rst_no_rsp", 32'(seen), 0);
    check_val("rst_ready", 32'(cmd_ready), 1);
    check_init();
    run_cmd(1'b1, 8'h04, 8'h00, 1'b1, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
